// File: rtl/bsg_line_write_gather_pkg.sv
// Shared types and default geometry for the masked line-write path
// (gather stage and bitmask expander).
package bsg_line_write_gather_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    GATHER = 2'd1,
    SEND   = 2'd2
  } gather_state_e;

  localparam int width_default     = 32;
  localparam int els_default       = 16;
  localparam int tag_width_default = 26;

endpackage

// File: rtl/bsg_line_write_gather_buf.sv
// Line buffer: els_p data words plus the per-word written mask.
// A load keeps only the words selected by we and rebuilds the mask from we.
module bsg_line_write_gather_buf #(
  parameter int width_p = 32,
  parameter int els_p   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     load,
  input  logic [els_p-1:0]         we,
  input  logic [width_p-1:0]       wdata,
  output logic [els_p*width_p-1:0] data,
  output logic [els_p-1:0]         mask
);

  logic [els_p-1:0][width_p-1:0] words_r;
  logic [els_p-1:0]              mask_r;

  // Word storage and mask; unwritten words are always held at zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      words_r <= {(els_p*width_p){1'b0}};
      mask_r  <= {els_p{1'b0}};
    end else if (clear) begin
      words_r <= {(els_p*width_p){1'b0}};
      mask_r  <= {els_p{1'b0}};
    end else if (load) begin
      for (int k = 0; k < els_p; k++) begin
        words_r[k] <= we[k] ? wdata : {width_p{1'b0}};
      end
      mask_r <= we;
    end else begin
      for (int k = 0; k < els_p; k++) begin
        if (we[k]) begin
          words_r[k] <= wdata;
        end
      end
      mask_r <= mask_r | we;
    end
  end

  assign data = words_r;
  assign mask = mask_r;

endmodule

// File: rtl/bsg_line_write_gather_chk.sv
// Simulation checker: the consumer may only take a line that is presented.
module bsg_line_write_gather_chk (
  input logic clk,
  input logic reset_n,
  input logic v,
  input logic yumi
);

  yumi_only_when_valid: assert property (@(posedge clk) disable iff (!reset_n) yumi |-> v);

endmodule

// File: rtl/bsg_line_write_gather.sv
// Gathers word writes to one cache line and emits the line with a per-word mask.
// Optional idle-timeout flush is enabled by defining BSG_LINE_WRITE_GATHER_TIMEOUT_EN.
module bsg_line_write_gather
  import bsg_line_write_gather_pkg::*;
#(
  parameter int width_p     = width_default,
  parameter int els_p       = els_default,
  parameter int tag_width_p = tag_width_default,
  parameter int timeout_p   = 64,
  localparam int lg_els_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic [tag_width_p-1:0]   tag_i,
  input  logic [lg_els_lp-1:0]     idx_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_o,
  input  logic                     flush_i,
  output logic                     v_o,
  output logic [tag_width_p-1:0]   tag_o,
  output logic [els_p*width_p-1:0] data_o,
  output logic [els_p-1:0]         mask_o,
  input  logic                     yumi_i
);

  localparam logic [els_p-1:0] full_mask_lp = {els_p{1'b1}};

  gather_state_e state_r, next_state_s;
  logic ready_r, v_r;
  logic [tag_width_p-1:0] tag_r, tag_next_s;
  logic tag_load_s;
  logic pend_v_r, pend_load_s, pend_clear_s;
  logic [tag_width_p-1:0] pend_tag_r;
  logic [lg_els_lp-1:0] pend_idx_r;
  logic [width_p-1:0] pend_data_r;
  logic buf_clear_s, buf_load_s, buf_we_s;
  logic [lg_els_lp-1:0] buf_idx_s;
  logic [width_p-1:0] buf_wdata_s;
  logic [els_p-1:0] onehot_s, we_vec_s, mask_s;
  logic accept_s, flush_s, timeout_s;

  assign accept_s = v_i & ready_r;
  assign flush_s  = flush_i | timeout_s;
  assign we_vec_s = (buf_load_s | buf_we_s) ? onehot_s : {els_p{1'b0}};

  // Decode of the word index currently steered into the buffer.
  always_comb begin
    for (int k = 0; k < els_p; k++) begin
      onehot_s[k] = (buf_idx_s == lg_els_lp'(k));
    end
  end

  // Next-state and buffer/pending control.
  always_comb begin
    next_state_s = state_r;
    buf_clear_s  = 1'b0;
    buf_load_s   = 1'b0;
    buf_we_s     = 1'b0;
    buf_idx_s    = idx_i;
    buf_wdata_s  = data_i;
    tag_load_s   = 1'b0;
    tag_next_s   = tag_i;
    pend_load_s  = 1'b0;
    pend_clear_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (accept_s) begin
          buf_load_s   = 1'b1;
          tag_load_s   = 1'b1;
          next_state_s = (onehot_s == full_mask_lp) ? SEND : GATHER;
        end else begin
          next_state_s = EMPTY;
        end
      end
      GATHER: begin
        if (accept_s && (tag_i == tag_r)) begin
          buf_we_s = 1'b1;
          if (((mask_s | onehot_s) == full_mask_lp) || flush_s) begin
            next_state_s = SEND;
          end else begin
            next_state_s = GATHER;
          end
        end else if (accept_s) begin
          pend_load_s  = 1'b1;
          next_state_s = SEND;
        end else if (flush_s) begin
          next_state_s = SEND;
        end else begin
          next_state_s = GATHER;
        end
      end
      SEND: begin
        if (yumi_i && pend_v_r) begin
          // Parked word from a different line seeds the next line.
          buf_load_s   = 1'b1;
          buf_idx_s    = pend_idx_r;
          buf_wdata_s  = pend_data_r;
          tag_load_s   = 1'b1;
          tag_next_s   = pend_tag_r;
          pend_clear_s = 1'b1;
          next_state_s = (onehot_s == full_mask_lp) ? SEND : GATHER;
        end else if (yumi_i) begin
          buf_clear_s  = 1'b1;
          next_state_s = EMPTY;
        end else begin
          next_state_s = SEND;
        end
      end
      default: begin
        buf_clear_s  = 1'b1;
        next_state_s = EMPTY;
      end
    endcase
  end

  // State, registered handshakes, line tag and pending entry.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r     <= EMPTY;
      ready_r     <= 1'b0;
      v_r         <= 1'b0;
      tag_r       <= {tag_width_p{1'b0}};
      pend_v_r    <= 1'b0;
      pend_tag_r  <= {tag_width_p{1'b0}};
      pend_idx_r  <= {lg_els_lp{1'b0}};
      pend_data_r <= {width_p{1'b0}};
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s != SEND);
      v_r     <= (next_state_s == SEND);
      if (tag_load_s) begin
        tag_r <= tag_next_s;
      end
      if (pend_load_s) begin
        pend_v_r    <= 1'b1;
        pend_tag_r  <= tag_i;
        pend_idx_r  <= idx_i;
        pend_data_r <= data_i;
      end else if (pend_clear_s) begin
        pend_v_r    <= 1'b0;
        pend_tag_r  <= {tag_width_p{1'b0}};
        pend_idx_r  <= {lg_els_lp{1'b0}};
        pend_data_r <= {width_p{1'b0}};
      end
    end
  end

`ifdef BSG_LINE_WRITE_GATHER_TIMEOUT_EN
  localparam int cnt_w_lp = $clog2(timeout_p + 1);
  logic [cnt_w_lp-1:0] idle_cnt_r;

  // Idle cycles spent in GATHER since the line opened or last took a word.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      idle_cnt_r <= {cnt_w_lp{1'b0}};
    end else if ((state_r != GATHER) || (next_state_s != GATHER) || accept_s) begin
      idle_cnt_r <= {cnt_w_lp{1'b0}};
    end else begin
      idle_cnt_r <= idle_cnt_r + {{(cnt_w_lp-1){1'b0}}, 1'b1};
    end
  end

  assign timeout_s = (state_r == GATHER) && (idle_cnt_r == cnt_w_lp'(timeout_p));
`else
  localparam int timeout_unused_lp = timeout_p;
  assign timeout_s = 1'b0;
`endif

  bsg_line_write_gather_buf #(
    .width_p(width_p),
    .els_p  (els_p)
  ) line_buf (
    .clk    (clk_i),
    .reset_n(reset_n_i),
    .clear  (buf_clear_s),
    .load   (buf_load_s),
    .we     (we_vec_s),
    .wdata  (buf_wdata_s),
    .data   (data_o),
    .mask   (mask_s)
  );

  bsg_line_write_gather_chk chk (
    .clk    (clk_i),
    .reset_n(reset_n_i),
    .v      (v_r),
    .yumi   (yumi_i)
  );

  assign ready_o = ready_r;
  assign v_o     = v_r;
  assign tag_o   = tag_r;
  assign mask_o  = mask_s;

endmodule

// File: tb/tb_bsg_line_write_gather.sv
// Randomized and directed bench for bsg_line_write_gather against a line-level reference model.
module tb_bsg_line_write_gather;

  localparam int W  = 32;
  localparam int E  = 16;
  localparam int T  = 26;
  localparam int TO = 4;
  localparam int CW = 512;

  logic clk = 1'b0;
  logic reset_n, v_i, flush_i, yumi_i;
  logic [T-1:0] tag_i;
  logic [3:0] idx_i;
  logic [W-1:0] data_i;
  logic ready_o, v_o;
  logic [T-1:0] tag_o;
  logic [E*W-1:0] data_o;
  logic [E-1:0] mask_o;

  bsg_line_write_gather #(
    .width_p(W), .els_p(E), .tag_width_p(T), .timeout_p(TO)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .tag_i(tag_i), .idx_i(idx_i),
    .data_i(data_i), .ready_o(ready_o), .flush_i(flush_i), .v_o(v_o), .tag_o(tag_o),
    .data_o(data_o), .mask_o(mask_o), .yumi_i(yumi_i)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // reference model: what the line looks like from outside
  bit m_rst = 1'b1, m_open = 1'b0, m_sealed = 1'b0, p_v = 1'b0, to_en = 1'b0;
  logic [T-1:0] m_tag = '0, p_tag = '0;
  logic [W-1:0] m_data[E];
  logic [E-1:0] m_mask = '0;
  logic [W-1:0] p_data = '0;
  int p_idx = 0;
  int idle = 0;

  task automatic check_eq(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_line();
    for (int k = 0; k < E; k++) m_data[k] = '0;
    m_mask = '0;
  endtask

  task automatic model_step(input bit v, input logic [T-1:0] t, input int i, input logic [W-1:0] d,
                            input bit fl, input bit y, input bit rn);
    bit acc, fl_now, opened;
    acc = v && !m_rst && !m_sealed;
    opened = 1'b0;
    if (!rn) begin
      m_rst = 1'b1; m_open = 1'b0; m_sealed = 1'b0; p_v = 1'b0; m_tag = '0; idle = 0;
      clear_line();
      return;
    end
    m_rst = 1'b0;
    if (m_sealed) begin
      if (y) begin
        m_sealed = 1'b0;
        clear_line();
        if (p_v) begin
          m_open = 1'b1; opened = 1'b1; m_tag = p_tag;
          m_data[p_idx] = p_data; m_mask[p_idx] = 1'b1; p_v = 1'b0;
          if (m_mask == {E{1'b1}}) m_sealed = 1'b1;
        end else begin
          m_open = 1'b0;
        end
      end
    end else if (!m_open) begin
      if (acc) begin
        m_open = 1'b1; opened = 1'b1; m_tag = t; m_data[i] = d; m_mask[i] = 1'b1;
        if (m_mask == {E{1'b1}}) m_sealed = 1'b1;
      end
    end else begin
      fl_now = fl || (to_en && idle == TO);
      if (acc && t == m_tag) begin
        m_data[i] = d; m_mask[i] = 1'b1;
        if (m_mask == {E{1'b1}} || fl_now) m_sealed = 1'b1;
      end else if (acc) begin
        p_v = 1'b1; p_tag = t; p_idx = i; p_data = d; m_sealed = 1'b1;
      end else if (fl_now) begin
        m_sealed = 1'b1;
      end
    end
    if (opened || m_sealed || !m_open) idle = 0;
    else idle = acc ? 0 : idle + 1;
  endtask

  task automatic cycle(input bit v, input logic [T-1:0] t, input int i, input logic [W-1:0] d,
                       input bit fl, input bit y, input bit rn);
    logic [E*W-1:0] exp_line;
    v_i = v; tag_i = t; idx_i = 4'(i); data_i = d; flush_i = fl; yumi_i = y; reset_n = rn;
    @(posedge clk);
    model_step(v, t, i, d, fl, y, rn);
    @(negedge clk);
    for (int k = 0; k < E; k++) exp_line[k*W +: W] = m_data[k];
    check_eq("v_o", CW'(v_o), CW'(m_sealed));
    check_eq("ready_o", CW'(ready_o), CW'(!m_rst && !m_sealed));
    check_eq("mask_o", CW'(mask_o), CW'(m_mask));
    check_eq("tag_o", CW'(tag_o), CW'(m_tag));
    check_eq("data_o", CW'(data_o), CW'(exp_line));
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, 0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic take();
    cycle(1'b0, '0, 0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic flush();
    cycle(1'b0, '0, 0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
`ifdef BSG_LINE_WRITE_GATHER_TIMEOUT_EN
    to_en = 1'b1;
`else
    to_en = 1'b0;
`endif
    for (int k = 0; k < E; k++) m_data[k] = '0;
    v_i = 1'b0; tag_i = '0; idx_i = '0; data_i = '0; flush_i = 1'b0; yumi_i = 1'b0; reset_n = 1'b0;

    // reset
    cycle(1'b0, '0, 0, '0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_v", CW'(v_o), CW'(0));
    check_eq("rst_ready", CW'(ready_o), CW'(0));
    check_eq("rst_mask", CW'(mask_o), CW'(0));
    idle_cycle();
    check_eq("ready_after_rst", CW'(ready_o), CW'(1));

    // full line
    for (int k = 0; k < E; k++) cycle(1'b1, 26'h10, k, 32'(k), 1'b0, 1'b0, 1'b1);
    check_eq("full_v", CW'(v_o), CW'(1));
    check_eq("full_mask", CW'(mask_o), CW'(16'hFFFF));
    check_eq("full_w9", CW'(data_o[9*W +: W]), CW'(9));
    check_eq("full_w15", CW'(data_o[15*W +: W]), CW'(15));
    take();
    check_eq("full_ready_after", CW'(ready_o), CW'(1));
    check_eq("full_v_after", CW'(v_o), CW'(0));

    // partial line via flush
    cycle(1'b1, 26'h20, 3, 32'hAA, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 26'h20, 7, 32'hBB, 1'b0, 1'b0, 1'b1);
    flush();
    check_eq("part_mask", CW'(mask_o), CW'(16'h0088));
    check_eq("part_w7", CW'(data_o[7*W +: W]), CW'(32'hBB));
    check_eq("part_w0", CW'(data_o[0 +: W]), CW'(0));
    idle_cycle();
    check_eq("part_tag_held", CW'(tag_o), CW'(26'h20));
    take();

    // tag switch
    cycle(1'b1, 26'h1, 0, 32'h11, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 26'h2, 5, 32'h55, 1'b0, 1'b0, 1'b1);
    check_eq("sw_v", CW'(v_o), CW'(1));
    check_eq("sw_tag", CW'(tag_o), CW'(26'h1));
    check_eq("sw_mask", CW'(mask_o), CW'(16'h0001));
    check_eq("sw_ready", CW'(ready_o), CW'(0));
    take();
    check_eq("sw_gather_v", CW'(v_o), CW'(0));
    flush();
    check_eq("sw2_tag", CW'(tag_o), CW'(26'h2));
    check_eq("sw2_mask", CW'(mask_o), CW'(16'h0020));
    check_eq("sw2_w5", CW'(data_o[5*W +: W]), CW'(32'h55));
    take();

    // overwrite and backpressure
    cycle(1'b1, 26'h3, 2, 32'h1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 26'h3, 2, 32'h2, 1'b0, 1'b0, 1'b1);
    flush();
    for (int n = 0; n < 5; n++) begin
      idle_cycle();
      check_eq("bp_v", CW'(v_o), CW'(1));
      check_eq("bp_w2", CW'(data_o[2*W +: W]), CW'(32'h2));
      check_eq("bp_mask", CW'(mask_o), CW'(16'h0004));
    end
    take();

    // reset while sending with a pending word
    cycle(1'b1, 26'h4, 0, 32'h44, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 26'h5, 5, 32'h99, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 0, '0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_send_v", CW'(v_o), CW'(0));
    check_eq("rst_send_mask", CW'(mask_o), CW'(0));
    idle_cycle();
    cycle(1'b1, 26'h6, 1, 32'h77, 1'b0, 1'b0, 1'b1);
    flush();
    check_eq("after_rst_mask", CW'(mask_o), CW'(16'h0002));
    check_eq("after_rst_tag", CW'(tag_o), CW'(26'h6));
    take();

    // idle timeout (or its absence)
    cycle(1'b1, 26'h7, 4, 32'h44, 1'b0, 1'b0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      idle_cycle();
      check_eq("timeout_v", CW'(v_o), CW'(to_en && n == 5));
    end
    for (int n = 0; n < 70; n++) idle_cycle();
    if (!m_sealed) flush();
    take();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit rn, v, fl, y;
      logic [T-1:0] t;
      rn = ($urandom_range(0, 149) != 0);
      v  = ($urandom_range(0, 3) != 0);
      t  = ($urandom_range(0, 9) == 0) ? T'($urandom_range(0, 3)) : m_tag;
      fl = ($urandom_range(0, 15) == 0);
      y  = rn && m_sealed && ($urandom_range(0, 1) == 1);
      cycle(v, t, int'($urandom_range(0, E-1)), $urandom, fl, y, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_line_write_gather.md
Name: bsg_line_write_gather

Overview:
- Upstream neighbour of the bitmask expander in the masked line-write path.
- Collects word-granular writes that target the same cache line into one line buffer.
- Emits the line with a per-word valid mask (els_p bits). Downstream, the expander turns that mask into a per-bit write mask.
- Handshakes: valid/ready on the input side; valid/yumi on the output side.

Parameters:
- width_p, 32, bits per word.
- els_p, 16, words per line; mask_o width.
- tag_width_p, 26, line-address tag width.
- timeout_p, 64, idle cycles before an automatic flush; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset, sampled on the clk_i rising edge.
- v_i  in  1  input word valid.
- tag_i  in  tag_width_p  line tag of the input word.
- idx_i  in  $clog2(els_p)  word index within the line.
- data_i  in  width_p  word data.
- ready_o  out  1  input accepted when v_i & ready_o; depends on state only.
- flush_i  in  1  request emission of a partial line.
- v_o  out  1  line valid.
- tag_o  out  tag_width_p  line tag.
- data_o  out  els_p*width_p  line data; word k at bits [k*width_p +: width_p].
- mask_o  out  els_p  bit k set = word k written.
- yumi_i  in  1  consumer takes the line; legal only when v_o = 1.

Behaviour:
- Reset (reset_n_i = 0 at a clock edge):
  - state = EMPTY.
  - mask, data, tag, pending all cleared.
  - v_o = 0; ready_o = 0 while reset_n_i is low, and 1 in the first cycle after reset releases.
- States: EMPTY, GATHER, SEND. All outputs are registered or state-decoded; there is no combinational path from input to output.
- EMPTY:
  - ready_o = 1.
  - On accept: load tag, write word idx_i, mask = onehot(idx_i).
  - Next state is GATHER, or SEND if the mask is now all ones (els_p = 1).
  - flush_i is ignored.
- GATHER:
  - ready_o = 1.
  - Accepted word with tag_i == tag: write the word and set its mask bit. A repeat index overwrites (last write wins).
  - If the mask becomes all ones, go to SEND. v_o rises on the cycle after the final word is accepted (latency 1).
  - Accepted word with tag_i != tag: capture it in a single-entry pending register (tag, idx, data); go to SEND. The current line is unchanged.
  - flush_i = 1: go to SEND. A same-cycle matching word is merged first; a same-cycle mismatching word goes to pending.
- SEND:
  - ready_o = 0; v_o = 1; outputs are held stable until yumi_i.
  - flush_i is ignored.
  - On yumi_i with pending: the buffer is reloaded from pending (data cleared except the pending word, mask = onehot), pending is cleared, next state GATHER (or SEND if els_p = 1).
  - On yumi_i without pending: data and mask cleared, next state EMPTY.
  - Back-to-back throughput is therefore at most one line per two cycles when lines switch.
- Unwritten words in data_o are always zero.
- Reset in any state, including SEND with pending set, discards all content. No line is emitted.
- yumi_i while v_o = 0 is illegal; it is asserted in simulation and ignored in RTL.

Optional Feature:
- Macro: BSG_LINE_WRITE_GATHER_TIMEOUT_EN.
- Defined:
  - A $clog2(timeout_p+1)-bit idle counter runs in GATHER.
  - It resets to 0 on any accepted word and on entry to GATHER.
  - It increments otherwise.
  - When it reaches timeout_p, the block behaves exactly as flush_i = 1 in that cycle.
  - The counter is cleared by reset.
- Undefined: no counter exists; a partial line leaves only on flush_i, on a tag mismatch, or when full.

Decomposition:
- Shared package bsg_line_write_gather_pkg:
  - State typedef (EMPTY, GATHER, SEND).
  - Default constants for width_p, els_p and tag_width_p, shared with the expander instantiation.
- One natural sub-module: bsg_line_write_gather_buf.
  - Contents: els_p x width_p data registers plus the mask register.
  - Controls: per-word write enable, synchronous clear, and load-onehot.
  - The FSM and pending register stay in the top.

Test Plan:
- Full line: reset; write tag 0x10, idx 0..15, data = idx, on 16 consecutive cycles → v_o = 1 on the next cycle; mask_o = 0xFFFF; data word k = k; yumi → EMPTY, ready_o = 1.
- Partial line via flush: write idx 3 = 0xAA and idx 7 = 0xBB, then flush_i → mask_o = 0x0088; other words 0; tag held until yumi.
- Tag switch: tag 0x1 idx 0, then tag 0x2 idx 5 = 0x55 → line (tag 0x1, mask 0x0001) emitted with ready_o = 0. After yumi: GATHER; a subsequent flush emits tag 0x2, mask 0x0020, word 5 = 0x55.
- Overwrite and backpressure: idx 2 = 0x1, then idx 2 = 0x2, flush, hold yumi_i low 5 cycles → outputs stable for all 5 cycles; word 2 = 0x2; mask 0x0004.
- Reset mid-SEND with pending set: assert reset_n_i = 0 for 1 cycle → v_o = 0; mask clears; the pending word is lost; the next line starts clean.
- With the macro defined and timeout_p = 4: one write, then idle → v_o = 1 exactly 5 cycles after the write is accepted (counter 0..4, flush on reaching 4). Without the macro: v_o stays 0 indefinitely.
